// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing/hazard controller.
// Optional build macro: PIPELINE_CTRL_FWD_EN (see pipeline_ctrl.sv).
package pipeline_ctrl_pkg;

  // Width of an architectural register index.
  localparam int unsigned RegIdxW = 5;

  // Shadow slot positions, youngest first.
  localparam int unsigned NumSlots = 3;
  localparam int unsigned SlotEx   = 0;
  localparam int unsigned SlotMem  = 1;
  localparam int unsigned SlotWb   = 2;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic               valid;
    logic [RegIdxW-1:0] rd;
    logic               we;
    logic               is_load;
  } shadow_slot_t;

  // A slot produces a value the ID instruction is about to read.
  function automatic logic slot_match(input shadow_slot_t slot, input logic [RegIdxW-1:0] rs,
                                      input logic use_rs);
    return slot.valid && slot.we && (slot.rd == rs) && (rs != '0) && use_rs;
  endfunction

  // Youngest producer wins: EX holds the newest value, then MEM, then WB.
  function automatic fwd_sel_t youngest_match(input logic [NumSlots-1:0] m);
    fwd_sel_t sel;
    if (m[SlotEx]) begin
      sel = FWD_EX;
    end else if (m[SlotMem]) begin
      sel = FWD_MEM;
    end else if (m[SlotWb]) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_inflight_tracker.sv
// Three-slot shadow of in-flight destination registers (EX, MEM, WB) with
// per-slot match vectors for the two ID source operands.
module pipeline_ctrl_inflight_tracker
  import pipeline_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance_i,
  input  logic                wb_kill_i,
  input  logic                flush_ex_i,
  input  shadow_slot_t        id_slot_i,
  input  logic [RegIdxW-1:0]  rs1_i,
  input  logic [RegIdxW-1:0]  rs2_i,
  input  logic                use_rs1_i,
  input  logic                use_rs2_i,
  output logic [NumSlots-1:0] rs1_match_o,
  output logic [NumSlots-1:0] rs2_match_o,
  output logic                ex_is_load_o
);

  shadow_slot_t ex_q, ex_d;
  shadow_slot_t mem_q, mem_d;
  shadow_slot_t wb_q, wb_d;

  // Shift the shadow on a normal edge; when frozen only the WB slot retires.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (advance_i) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (flush_ex_i) begin
        mem_d.valid = 1'b0;
      end
      ex_d = id_slot_i;
    end else if (wb_kill_i) begin
      wb_d.valid = 1'b0;
    end
  end

  // Shadow slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Per-slot source operand matches.
  always_comb begin
    rs1_match_o          = '0;
    rs2_match_o          = '0;
    rs1_match_o[SlotEx]  = slot_match(ex_q, rs1_i, use_rs1_i);
    rs1_match_o[SlotMem] = slot_match(mem_q, rs1_i, use_rs1_i);
    rs1_match_o[SlotWb]  = slot_match(wb_q, rs1_i, use_rs1_i);
    rs2_match_o[SlotEx]  = slot_match(ex_q, rs2_i, use_rs2_i);
    rs2_match_o[SlotMem] = slot_match(mem_q, rs2_i, use_rs2_i);
    rs2_match_o[SlotWb]  = slot_match(wb_q, rs2_i, use_rs2_i);
    ex_is_load_o         = ex_q.is_load;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/bubble/flush/redirect controller for the five-stage core.
// Build option: define PIPELINE_CTRL_FWD_EN to enable operand forwarding
// selects; otherwise every in-flight producer match stalls ID.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [$clog2(NREGS)-1:0] id_rs1,
  input  logic [$clog2(NREGS)-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [$clog2(NREGS)-1:0] id_rd,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic                     ex_br_valid,
  input  logic                     ex_taken,
  input  logic [XLEN-1:0]          ex_target,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     stall_ex,
  output logic                     stall_mem,
  output logic                     bubble_ex,
  output logic                     flush_if,
  output logic                     flush_id,
  output logic                     flush_ex,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [1:0]               fwd_rs1_sel,
  output logic [1:0]               fwd_rs2_sel
);

  ctrl_state_t     state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic                mem_stall;
  logic                in_redirect;
  logic                hazard;
  logic [NumSlots-1:0] rs1_match;
  logic [NumSlots-1:0] rs2_match;
  logic                ex_is_load;
  shadow_slot_t        id_slot;
  fwd_sel_t            fwd_rs1;
  fwd_sel_t            fwd_rs2;

  // Gated by rst_n so every output is 0 while reset is held.
  assign mem_stall   = rst_n && mem_req && !mem_ready;
  assign in_redirect = (state_q == REDIRECT);

  // What ID hands to the EX slot on the next unfrozen edge.
  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid && !stall_id && !flush_id;
    id_slot.rd      = id_rd;
    id_slot.we      = id_we;
    id_slot.is_load = id_is_load;
  end

  pipeline_ctrl_inflight_tracker u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance_i    (!mem_stall),
    .wb_kill_i    (mem_stall),
    .flush_ex_i   (flush_ex),
    .id_slot_i    (id_slot),
    .rs1_i        (id_rs1),
    .rs2_i        (id_rs2),
    .use_rs1_i    (id_use_rs1),
    .use_rs2_i    (id_use_rs2),
    .rs1_match_o  (rs1_match),
    .rs2_match_o  (rs2_match),
    .ex_is_load_o (ex_is_load)
  );

  // Hazard detection and forwarding selects.
`ifdef PIPELINE_CTRL_FWD_EN
  always_comb begin
    // Only a load still in EX cannot be forwarded in time.
    hazard  = (rs1_match[SlotEx] || rs2_match[SlotEx]) && ex_is_load;
    fwd_rs1 = youngest_match(rs1_match);
    fwd_rs2 = youngest_match(rs2_match);
  end
`else
  logic unused_ex_is_load;
  assign unused_ex_is_load = ex_is_load;

  always_comb begin
    // No write-through in the register file: even a WB producer must stall.
    hazard  = (|rs1_match) || (|rs2_match);
    fwd_rs1 = FWD_RF;
    fwd_rs2 = FWD_RF;
  end
`endif

  // Redirect FSM next-state; target is captured only on entry to REDIRECT.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = '0;
    unique case (state_q)
      RUN: begin
        if (ex_br_valid && ex_taken && !mem_stall) begin
          state_d       = REDIRECT;
          redirect_pc_d = ex_target;
        end
      end
      REDIRECT: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Redirect FSM state and captured target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Stage controls: memory stall beats redirect, redirect beats data hazard.
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    bubble_ex      = 1'b0;
    flush_if       = in_redirect;
    flush_id       = in_redirect;
    flush_ex       = in_redirect;
    redirect_valid = in_redirect;
    redirect_pc    = redirect_pc_q;
    fwd_rs1_sel    = fwd_rs1;
    fwd_rs2_sel    = fwd_rs2;
    if (mem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (!in_redirect && hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-scenario stimulus tables with a
// queue of expected outputs popped and compared each cycle.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_we, id_is_load;
  logic        ex_br_valid, ex_taken;
  logic [31:0] ex_target;
  logic        mem_req, mem_ready;
  logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex;
  logic        flush_if, flush_id, flush_ex, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;

  pipeline_ctrl #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_is_load     (id_is_load),
    .ex_br_valid    (ex_br_valid),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .bubble_ex      (bubble_ex),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fwd_rs1_sel    (fwd_rs1_sel),
    .fwd_rs2_sel    (fwd_rs2_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        mreq;
    logic        mrdy;
  } stim_t;

  // ctl = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
  //        flush_if, flush_id, flush_ex, redirect_valid}
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] pc;
    logic [1:0]  f1;
    logic [1:0]  f2;
  } obs_t;

  localparam logic [8:0] CNone = 9'b000000000;
  localparam logic [8:0] CHaz  = 9'b110010000;
  localparam logic [8:0] CMem  = 9'b111100000;
  localparam logic [8:0] CRdr  = 9'b000001111;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd, input logic we,
                                input logic ld);
    stim_t s;
    s     = '0;
    s.v   = 1'b1;
    s.rs1 = rs1;
    s.rs2 = rs2;
    s.u1  = u1;
    s.u2  = u2;
    s.rd  = rd;
    s.we  = we;
    s.ld  = ld;
    return s;
  endfunction

  function automatic stim_t with_br(input stim_t base, input logic [31:0] tgt);
    stim_t s;
    s     = base;
    s.br  = 1'b1;
    s.tk  = 1'b1;
    s.tgt = tgt;
    return s;
  endfunction

  function automatic stim_t with_mem(input stim_t base, input logic rdy);
    stim_t s;
    s      = base;
    s.mreq = 1'b1;
    s.mrdy = rdy;
    return s;
  endfunction

  function automatic obs_t mk(input logic [8:0] ctl, input logic [31:0] pc, input logic [1:0] f1,
                              input logic [1:0] f2);
    obs_t o;
    o.ctl = ctl;
    o.pc  = pc;
    o.f1  = f1;
    o.f2  = f2;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ctl = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
             flush_if, flush_id, flush_ex, redirect_valid};
    o.pc  = redirect_pc;
    o.f1  = fwd_rs1_sel;
    o.f2  = fwd_rs2_sel;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    id_valid    = s.v;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_use_rs1  = s.u1;
    id_use_rs2  = s.u2;
    id_rd       = s.rd;
    id_we       = s.we;
    id_is_load  = s.ld;
    ex_br_valid = s.br;
    ex_taken    = s.tk;
    ex_target   = s.tgt;
    mem_req     = s.mreq;
    mem_ready   = s.mrdy;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    apply(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = observe();
    n_cmp++;
    if (got !== mk(CNone, 32'h0, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", got, mk(CNone, 32'h0, 2'b00, 2'b00));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Data hazard: three stall cycles without forwarding, EX/MEM selects with it.
  task automatic test_hazard();
    stim_t s[$];
    obs_t  e[$];
    for (int i = 0; i < 3; i++) begin
      s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
`ifdef PIPELINE_CTRL_FWD_EN
    s.push_back(ins(0, 0, 0, 0, 5, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(5, 1, 1, 1, 6, 1, 0)); e.push_back(mk(CNone, 0, 2'b01, 2'b00));
    for (int i = 0; i < 3; i++) begin
      s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
    s.push_back(ins(0, 0, 0, 0, 5, 1, 1)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(5, 5, 1, 1, 6, 1, 0)); e.push_back(mk(CHaz, 0, 2'b01, 2'b01));
    s.push_back(ins(5, 5, 1, 1, 6, 1, 0)); e.push_back(mk(CNone, 0, 2'b10, 2'b10));
    s.push_back(ins(6, 0, 1, 0, 7, 1, 0)); e.push_back(mk(CNone, 0, 2'b01, 2'b00));
    s.push_back(ins(0, 6, 0, 1, 8, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b10));
    s.push_back(ins(6, 7, 1, 1, 0, 0, 0)); e.push_back(mk(CNone, 0, 2'b11, 2'b10));
`else
    s.push_back(ins(0, 0, 0, 0, 5, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) begin
      s.push_back(ins(5, 1, 1, 1, 6, 1, 0)); e.push_back(mk(CHaz, 0, 2'b00, 2'b00));
    end
    s.push_back(ins(5, 1, 1, 1, 6, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 6, 0, 1, 0, 0, 0)); e.push_back(mk(CHaz, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 6, 0, 0, 0, 0, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
`endif
    s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      begin
        obs_t got, want;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL hazard cyc%0d: got %h want %h", i, got, want);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Writes to x0 never create a dependency.
  task automatic test_x0();
    stim_t s[$];
    obs_t  e[$];
    for (int i = 0; i < 3; i++) begin
      s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
    s.push_back(ins(0, 0, 0, 0, 0, 1, 1)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 0, 1, 1, 0, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 0, 1, 1, 3, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      begin
        obs_t got, want;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL x0_dep cyc%0d: got %h want %h", i, got, want);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Taken branch: one-cycle registered redirect; wrong-path producers are flushed.
  task automatic test_branch();
    stim_t s[$];
    obs_t  e[$];
    for (int i = 0; i < 3; i++) begin
      s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
    s.push_back(with_br(ins(0, 0, 0, 0, 7, 1, 0), 32'h100));
    e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 0, 0, 0, 9, 1, 0)); e.push_back(mk(CRdr, 32'h100, 2'b00, 2'b00));
    s.push_back(ins(7, 9, 1, 1, 0, 0, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    // Not-taken branch does nothing.
    begin
      stim_t nt;
      nt    = idle();
      nt.br = 1'b1;
      nt.tgt = 32'h500;
      s.push_back(nt); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
    s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      begin
        obs_t got, want;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL branch cyc%0d: got %h want %h", i, got, want);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Memory stall holds off a taken branch; WB slot drains during the stall.
  task automatic test_mem_stall();
    stim_t s[$];
    obs_t  e[$];
    for (int i = 0; i < 3; i++) begin
      s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
    s.push_back(ins(0, 0, 0, 0, 8, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 0, 0, 0, 10, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(with_mem(with_br(idle(), 32'h200), 1'b0));
    e.push_back(mk(CMem, 0, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) begin
      s.push_back(with_mem(with_br(ins(8, 0, 1, 0, 0, 0, 0), 32'h200), 1'b0));
      e.push_back(mk(CMem, 0, 2'b00, 2'b00));
    end
    s.push_back(with_mem(with_br(ins(8, 0, 1, 0, 0, 0, 0), 32'h200), 1'b1));
    e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(idle()); e.push_back(mk(CRdr, 32'h200, 2'b00, 2'b00));
    s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      begin
        obs_t got, want;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL mem_stall cyc%0d: got %h want %h", i, got, want);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Consecutive taken branches and an independent instruction stream.
  task automatic test_back_to_back();
    stim_t s[$];
    obs_t  e[$];
    for (int i = 0; i < 3; i++) begin
      s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    end
    s.push_back(with_br(ins(0, 0, 0, 0, 11, 1, 0), 32'h40));
    e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(with_br(idle(), 32'h80)); e.push_back(mk(CRdr, 32'h40, 2'b00, 2'b00));
    s.push_back(with_br(idle(), 32'h80)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(idle()); e.push_back(mk(CRdr, 32'h80, 2'b00, 2'b00));
    s.push_back(ins(11, 0, 1, 0, 0, 0, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(0, 0, 0, 0, 12, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(1, 0, 1, 0, 13, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(ins(2, 3, 1, 1, 14, 1, 0)); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    s.push_back(idle()); e.push_back(mk(CNone, 0, 2'b00, 2'b00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      begin
        obs_t got, want;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL back_to_back cyc%0d: got %h want %h", i, got, want);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset during a memory stall and during a redirect.
  task automatic test_reset_async();
    obs_t got;
    apply(with_mem(idle(), 1'b0));
    #1;
    got = observe();
    n_cmp++;
    if (got !== mk(CMem, 0, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL rst_pre_stall: got %h want %h", got, mk(CMem, 0, 2'b00, 2'b00));
    end
    rst_n = 1'b0;
    #1;
    got = observe();
    n_cmp++;
    if (got !== mk(CNone, 0, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL rst_mid_stall: got %h want %h", got, mk(CNone, 0, 2'b00, 2'b00));
    end
    apply(idle());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(with_br(idle(), 32'h300));
    @(posedge clk);
    #1;
    apply(idle());
    #1;
    got = observe();
    n_cmp++;
    if (got !== mk(CRdr, 32'h300, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL rst_pre_redirect: got %h want %h", got, mk(CRdr, 32'h300, 2'b00, 2'b00));
    end
    rst_n = 1'b0;
    #1;
    got = observe();
    n_cmp++;
    if (got !== mk(CNone, 0, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL rst_mid_redirect: got %h want %h", got, mk(CNone, 0, 2'b00, 2'b00));
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got = observe();
    n_cmp++;
    if (got !== mk(CNone, 0, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL rst_release: got %h want %h", got, mk(CNone, 0, 2'b00, 2'b00));
    end
    @(posedge clk);
    #1;
    apply(with_br(idle(), 32'h44));
    @(posedge clk);
    #1;
    apply(idle());
    #1;
    got = observe();
    n_cmp++;
    if (got !== mk(CRdr, 32'h44, 2'b00, 2'b00)) begin
      n_bad++;
      $display("FAIL rst_run_after: got %h want %h", got, mk(CRdr, 32'h44, 2'b00, 2'b00));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hazard();
    test_x0();
    test_branch();
    test_mem_stall();
    test_back_to_back();
    test_reset_async();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing and hazard controller for the five-stage RISC-V core (IF, ID, EX, MEM, WB). It shadows the destination registers of in-flight instructions and generates stall, bubble, flush and PC-redirect controls. When forwarding is compiled in, it also drives the operand-forwarding selects for the executor. It sits beside the datapath and owns every pipeline-advance decision; stage registers only obey its controls.

## Interface
Parameters:
- XLEN, 32, address/PC width
- NREGS, 32, architectural register count (x0 hard-wired zero)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5  source register indices
- id_use_rs1, id_use_rs2  in  1  instruction reads that source
- id_rd  in  5  destination index
- id_we  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- ex_br_valid  in  1  EX holds a resolved branch/jump
- ex_taken  in  1  branch/jump taken
- ex_target  in  XLEN  redirect target
- mem_req  in  1  MEM stage has an outstanding memory access
- mem_ready  in  1  memory completes this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold stage register
- bubble_ex  out  1  inject no-op into EX
- flush_if, flush_id, flush_ex  out  1  convert stage contents to no-op
- redirect_valid  out  1  load PC from redirect_pc
- redirect_pc  out  XLEN  new PC
- fwd_rs1_sel, fwd_rs2_sel  out  2  operand source (forwarding build only; tied 0 otherwise)

## Operation
- Shadow: three slots, EX/MEM/WB, each holding {valid, rd, we, is_load}. On a non-frozen edge: WB←MEM, MEM←EX (valid cleared if flush_ex), EX←ID (valid only if id_valid && !stall_id && !flush_id).
- mem_stall = mem_req && !mem_ready. It asserts stall_if/id/ex/mem and freezes the shadow, except that the WB slot becomes invalid.
- A slot matches rs when valid && we && rd==rs && rs!=0 && use_rs.
- Hazard (no forwarding): any slot matches rs1 or rs2 → stall_if, stall_id, bubble_ex.
- FSM states: RUN, REDIRECT.
  - RUN → REDIRECT when ex_br_valid && ex_taken && !mem_stall.
  - REDIRECT → RUN unconditionally after one cycle.
- REDIRECT cycle:
  - redirect_valid=1 and redirect_pc=registered ex_target.
  - flush_if=flush_id=flush_ex=1.
  - stall_id and bubble_ex are forced 0.
- Priority: mem_stall > REDIRECT > hazard. Branch resolution is ignored while mem_stall and is re-evaluated when EX unfreezes.
- Not-taken branches cause no action.

## Timing
- Reset: all outputs 0, state RUN, all slots invalid, redirect_pc 0. Reset asserted mid-stall or mid-redirect returns to this state immediately.
- Stall, bubble, hazard and fwd outputs are combinational from the shadow and ID inputs in the same cycle.
- Redirect outputs are registered: a taken branch sampled at edge t produces redirect/flush for exactly one cycle, t to t+1.
- Load-use penalty is 1 cycle with forwarding. Without forwarding, the penalty is up to 3 cycles; the register file has no write-through, so a WB-slot match still stalls.

## Configuration
- PIPELINE_CTRL_FWD_EN defined:
  - Hazard stall fires only when the EX slot matches and is_load.
  - Otherwise fwd_rsN_sel selects the youngest match: EX=01, MEM=10, WB=11, none=00.
- Undefined: fwd selects are constant 00 and every slot match stalls.

## Structure
- defs.sv gains ctrl_state_t (RUN, REDIRECT), fwd_sel_t (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and shadow_slot_t struct.
- One sub-module, inflight_tracker: the three-slot shadow plus match logic. It is instantiated once and queried for rs1 and rs2.

## Test plan
- Reset mid-REDIRECT: drop rst_n → all outputs 0 asynchronously; state RUN after release.
- No fwd: "add x5,…" then "add x6,x5,x1" → stall_id=1 for 3 cycles; second instruction issues with bubble_ex in each stalled cycle.
- FWD_EN: "lw x5" then "add x6,x5,x5" → one stall cycle, then fwd_rs1_sel=fwd_rs2_sel=10. "add x5" then dependent add → no stall, sel=01.
- x0 dependency: id_rd=0 producer, consumer reads x0 → never stalls, sel 00.
- Taken branch (ex_target=0x100) → next cycle redirect_valid=1, redirect_pc=0x100, three flushes; the flushed EX slot never causes a hazard.
- mem_stall for 4 cycles with a taken branch in EX → no redirect until mem_ready; redirect the cycle after mem_ready; WB slot empty during the stall.
